// File: rtl/switch_allocator_if.sv
// Handshake bundle between the input buffers, the switch allocator and the crossbar.
// The master modport drives the buffer/downstream status, and the slave modport is the allocator side.
interface switch_allocator_if;
    logic [4:0]  have_data;
    logic [4:0]  is_head;
    logic [4:0]  is_tail;
    logic [79:0] dst_x;
    logic [79:0] dst_y;
    logic [4:0]  out_ready;
    logic [4:0]  read_enable;
    logic [14:0] out_sel;
    logic [4:0]  out_valid;
    logic [4:0]  timeout_err;

    modport master (
        output have_data, is_head, is_tail, dst_x, dst_y, out_ready,
        input  read_enable, out_sel, out_valid, timeout_err
    );

    modport slave (
        input  have_data, is_head, is_tail, dst_x, dst_y, out_ready,
        output read_enable, out_sel, out_valid, timeout_err
    );
endinterface

// File: rtl/switch_allocator.sv
// Packet-level XY allocator for one 5-port mesh switch: per-output round-robin grant with wormhole lock.
// Define SWITCH_ALLOC_TIMEOUT_EN to add a per-output stall watchdog that force-releases a stuck lock.
module switch_allocator #(
    parameter logic [15:0] X       = 16'd1,
    parameter logic [15:0] Y       = 16'd1,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input logic          clk,
    input logic          rst,
    switch_allocator_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
    localparam int unsigned NP = 5;

    state_e     state_q [NP];
    state_e     state_d [NP];
    logic [2:0] sel_q   [NP];
    logic [2:0] sel_d   [NP];
    logic [2:0] ptr_q   [NP];
    logic [2:0] ptr_d   [NP];
    logic [4:0] req     [NP];
    logic [4:0] bound;
    logic [4:0] re;
    logic [4:0] ov;

`ifdef SWITCH_ALLOC_TIMEOUT_EN
    logic [7:0] cnt_q [NP];
    logic [7:0] cnt_d [NP];
    logic [4:0] terr_q;
    logic [4:0] terr_d;
`else
    logic       unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Dimension-ordered route: X is resolved completely before Y is considered.
    function automatic logic [2:0] route_of(input logic [15:0] dx, input logic [15:0] dy);
        if (dx > X)      return 3'd2;
        else if (dx < X) return 3'd4;
        else if (dy > Y) return 3'd1;
        else if (dy < Y) return 3'd3;
        else             return 3'd0;
    endfunction

    function automatic logic [2:0] pick(input logic [4:0] r, input logic [2:0] ptr);
        logic [2:0]  w;
        logic        found;
        int unsigned idx;
        w     = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NP; k++) begin
            idx = (32'(ptr) + k) % NP;
            if (!found && r[idx[2:0]]) begin
                w     = idx[2:0];
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        bound = '0;
        for (int unsigned o = 0; o < NP; o++)
            if (state_q[o] == BUSY) bound[sel_q[o]] = 1'b1;
    end

    always_comb begin
        for (int unsigned o = 0; o < NP; o++) req[o] = '0;
        for (int unsigned i = 0; i < NP; i++)
            if (bus.have_data[i] && bus.is_head[i] && !bound[i])
                req[route_of(bus.dst_x[16*i +: 16], bus.dst_y[16*i +: 16])][i] = 1'b1;
    end

    always_comb begin
        logic [2:0] s;
        logic       xf;
        s  = '0;
        xf = 1'b0;
        re = '0;
        ov = '0;
        for (int unsigned o = 0; o < NP; o++) begin
            state_d[o] = state_q[o];
            sel_d[o]   = sel_q[o];
            ptr_d[o]   = ptr_q[o];
`ifdef SWITCH_ALLOC_TIMEOUT_EN
            cnt_d[o]   = cnt_q[o];
`endif
        end
`ifdef SWITCH_ALLOC_TIMEOUT_EN
        terr_d = '0;
`endif
        for (int unsigned o = 0; o < NP; o++) begin
            s  = sel_q[o];
            xf = bus.have_data[s] & bus.out_ready[o];
            if (state_q[o] == IDLE) begin
`ifdef SWITCH_ALLOC_TIMEOUT_EN
                cnt_d[o] = '0;
`endif
                if (|req[o]) begin
                    state_d[o] = BUSY;
                    sel_d[o]   = pick(req[o], ptr_q[o]);
                end
            end else begin
                ov[o] = xf;
                if (xf) re[s] = 1'b1;
                if (xf) begin
`ifdef SWITCH_ALLOC_TIMEOUT_EN
                    cnt_d[o] = '0;
`endif
                    if (bus.is_tail[s]) begin
                        state_d[o] = IDLE;
                        ptr_d[o]   = s;
                    end
                end
`ifdef SWITCH_ALLOC_TIMEOUT_EN
                else if (cnt_q[o] + 8'd1 == TIMEOUT) begin
                    state_d[o] = IDLE;
                    ptr_d[o]   = s;
                    cnt_d[o]   = '0;
                    terr_d[o]  = 1'b1;
                end else begin
                    cnt_d[o] = cnt_q[o] + 8'd1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned o = 0; o < NP; o++) begin
                state_q[o] <= IDLE;
                sel_q[o]   <= '0;
                ptr_q[o]   <= 3'd4;
            end
        end else begin
            for (int unsigned o = 0; o < NP; o++) begin
                state_q[o] <= state_d[o];
                sel_q[o]   <= sel_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

`ifdef SWITCH_ALLOC_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned o = 0; o < NP; o++) cnt_q[o] <= '0;
            terr_q <= '0;
        end else begin
            for (int unsigned o = 0; o < NP; o++) cnt_q[o] <= cnt_d[o];
            terr_q <= terr_d;
        end
    end
    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = '0;
`endif

    always_comb begin
        bus.out_sel = '0;
        for (int unsigned o = 0; o < NP; o++) bus.out_sel[3*o +: 3] = sel_q[o];
    end

    assign bus.read_enable = re;
    assign bus.out_valid   = ov;
endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios plus random packet traffic,
// compared each cycle against a packet-level reference model of XY routing and round-robin locking.
module tb_switch_allocator;
    localparam int TO = 4;
    localparam int MX = 1;
    localparam int MY = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    switch_allocator_if bus();

    switch_allocator #(.X(16'(MX)), .Y(16'(MY)), .TIMEOUT(8'(TO))) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model: owner of each output (-1 free), last served input, stall count
    int owner [5];
    int last  [5];
    int stall [5];
    bit terr_exp [5];

    // packet generators, one per input buffer
    int   glen  [5];
    int   gpos  [5];
    int   gdx   [5];
    int   gdy   [5];
    bit   gmask [5];
    logic [4:0] rdy;

    int cyc = 0;
    int c0  = 0;
    int terr_seen = 0;
    int popq_in  [$];
    int popq_cyc [$];
    int exp_in  [8];
    int exp_cyc [8];

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int route_m(input int dx, input int dy);
        if (dx > MX) return 2;
        if (dx < MX) return 4;
        if (dy > MY) return 1;
        if (dy < MY) return 3;
        return 0;
    endfunction

    task automatic start(input int i, input int len, input int dx, input int dy);
        glen[i]  = len;
        gpos[i]  = 0;
        gdx[i]   = dx;
        gdy[i]   = dy;
        gmask[i] = 1'b1;
    endtask

    task automatic drive();
        for (int i = 0; i < 5; i++) begin
            bus.have_data[i] = (glen[i] > 0) && gmask[i];
            bus.is_head[i]   = (gpos[i] == 0);
            bus.is_tail[i]   = (glen[i] == 1);
            bus.dst_x[16*i +: 16] = 16'(gdx[i]);
            bus.dst_y[16*i +: 16] = 16'(gdy[i]);
        end
        bus.out_ready = rdy;
    endtask

    task automatic clear_log();
        popq_in.delete();
        popq_cyc.delete();
        c0 = cyc;
    endtask

    task automatic chk_log(input string tag, input int n);
        chk({tag, " pop count"}, 32'(popq_in.size()), 32'(n));
        for (int k = 0; k < n && k < popq_in.size(); k++) begin
            chk($sformatf("%s pop%0d input", tag, k), 32'(popq_in[k]), 32'(exp_in[k]));
            chk($sformatf("%s pop%0d cycle", tag, k), 32'(popq_cyc[k] - c0), 32'(exp_cyc[k]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset read_enable", 32'(bus.read_enable), 32'd0);
        chk("reset out_valid",   32'(bus.out_valid),   32'd0);
        chk("reset out_sel",     32'(bus.out_sel),     32'd0);
        chk("reset timeout_err", 32'(bus.timeout_err), 32'd0);
        for (int o = 0; o < 5; o++) begin
            owner[o] = -1;
            last[o] = 4;
            stall[o] = 0;
            terr_exp[o] = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            glen[i] = 0;
            gpos[i] = 0;
        end
    endtask

    task automatic cycle();
        logic [4:0] hd, e_re, e_ov, e_te;
        bit mv [5];
        bit isb [5];
        bit nb [5];
        int nown [5];
        int s, best, c;
        @(negedge clk);
        rst = 1'b0;
        drive();
        #1;
        e_re = '0;
        e_ov = '0;
        for (int i = 0; i < 5; i++) hd[i] = (glen[i] > 0) && gmask[i];
        for (int o = 0; o < 5; o++) begin
            e_te[o] = terr_exp[o];
            mv[o] = 1'b0;
            if (owner[o] >= 0) begin
                s = owner[o];
                mv[o] = hd[s] && rdy[o];
                e_ov[o] = mv[o];
                if (mv[o]) e_re[s] = 1'b1;
            end
        end
        chk("read_enable", 32'(bus.read_enable), 32'(e_re));
        chk("out_valid",   32'(bus.out_valid),   32'(e_ov));
        chk("timeout_err", 32'(bus.timeout_err), 32'(e_te));
        for (int o = 0; o < 5; o++)
            if (owner[o] >= 0)
                chk($sformatf("out_sel[%0d]", o), 32'(bus.out_sel[3*o +: 3]), 32'(owner[o]));
        terr_seen += $countones(bus.timeout_err);

        for (int i = 0; i < 5; i++) isb[i] = 1'b0;
        for (int o = 0; o < 5; o++) if (owner[o] >= 0) isb[owner[o]] = 1'b1;
        for (int o = 0; o < 5; o++) begin
            nown[o] = owner[o];
            terr_exp[o] = 1'b0;
        end
        for (int o = 0; o < 5; o++) begin
            if (owner[o] >= 0) begin
                s = owner[o];
                if (mv[o]) begin
                    stall[o] = 0;
                    if (glen[s] == 1) begin
                        nown[o] = -1;
                        last[o] = s;
                    end
                end
`ifdef SWITCH_ALLOC_TIMEOUT_EN
                else begin
                    stall[o]++;
                    if (stall[o] == TO) begin
                        nown[o] = -1;
                        last[o] = s;
                        stall[o] = 0;
                        terr_exp[o] = 1'b1;
                    end
                end
`endif
            end else begin
                stall[o] = 0;
                best = -1;
                for (int k = 1; k <= 5; k++) begin
                    c = (last[o] + k) % 5;
                    if (best < 0 && hd[c] && gpos[c] == 0 && !isb[c] && route_m(gdx[c], gdy[c]) == o)
                        best = c;
                end
                nown[o] = best;
            end
        end
        for (int o = 0; o < 5; o++) owner[o] = nown[o];
        for (int i = 0; i < 5; i++) begin
            if (e_re[i]) begin
                popq_in.push_back(i);
                popq_cyc.push_back(cyc);
                gpos[i]++;
                glen[i]--;
            end
        end
        // a packet cut off from its output is dropped by the buffer
        for (int i = 0; i < 5; i++) nb[i] = 1'b0;
        for (int o = 0; o < 5; o++) if (owner[o] >= 0) nb[owner[o]] = 1'b1;
        for (int i = 0; i < 5; i++) if (glen[i] > 0 && gpos[i] > 0 && !nb[i]) glen[i] = 0;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            glen[i] = 0; gpos[i] = 0; gdx[i] = 0; gdy[i] = 0; gmask[i] = 1'b1;
        end
        rdy = 5'h1F;
        drive();

        // single 3-flit packet to EAST
        do_reset();
        start(0, 3, 3, 1);
        clear_log();
        run(6);
        exp_in  = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_cyc = '{1, 2, 3, 0, 0, 0, 0, 0};
        chk_log("t1", 3);

        // three single-flit packets contending for LOCAL
        do_reset();
        start(1, 1, 1, 1);
        start(3, 1, 1, 1);
        start(4, 1, 1, 1);
        clear_log();
        run(8);
        exp_in  = '{1, 3, 4, 0, 0, 0, 0, 0};
        exp_cyc = '{1, 3, 5, 0, 0, 0, 0, 0};
        chk_log("t2", 3);

        // SOUTH and NORTH in parallel
        do_reset();
        start(0, 2, 1, 0);
        start(2, 2, 1, 2);
        clear_log();
        run(4);
        exp_in  = '{0, 2, 0, 2, 0, 0, 0, 0};
        exp_cyc = '{1, 1, 2, 2, 0, 0, 0, 0};
        chk_log("t3", 4);

        // downstream backpressure mid-packet
        do_reset();
        start(0, 5, 3, 1);
        clear_log();
        run(3);
        rdy[2] = 1'b0;
        run(3);
        rdy = 5'h1F;
        run(5);
        exp_in  = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_cyc = '{1, 2, 6, 7, 8, 0, 0, 0};
        chk_log("t4", 5);

        // reset mid-packet, then fresh arbitration from the reset pointer
        do_reset();
        start(0, 4, 3, 1);
        clear_log();
        run(3);
        exp_in  = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_cyc = '{1, 2, 0, 0, 0, 0, 0, 0};
        chk_log("t5a", 2);
        do_reset();
        start(1, 1, 3, 1);
        start(0, 1, 2, 1);
        clear_log();
        run(5);
        exp_in  = '{0, 1, 0, 0, 0, 0, 0, 0};
        exp_cyc = '{1, 3, 0, 0, 0, 0, 0, 0};
        chk_log("t5b", 2);

        // source dries up mid-packet with a competitor waiting
        do_reset();
        start(0, 3, 3, 1);
        clear_log();
        run(2);
        gmask[0] = 1'b0;
        start(1, 1, 3, 1);
        terr_seen = 0;
        run(8);
`ifdef SWITCH_ALLOC_TIMEOUT_EN
        exp_in  = '{0, 1, 0, 0, 0, 0, 0, 0};
        exp_cyc = '{1, 7, 0, 0, 0, 0, 0, 0};
        chk_log("t6", 2);
        chk("t6 timeout pulses", 32'(terr_seen), 32'd1);
`else
        exp_in  = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_cyc = '{1, 0, 0, 0, 0, 0, 0, 0};
        chk_log("t6", 1);
        chk("t6 timeout pulses", 32'(terr_seen), 32'd0);
`endif
        gmask[0] = 1'b1;

        // random traffic, occasional reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) do_reset();
            for (int i = 0; i < 5; i++) begin
                int r;
                if (glen[i] == 0 && $urandom_range(0, 3) == 0) begin
                    r = $urandom_range(0, 3);
                    start(i, $urandom_range(1, 4), (r == 3) ? 65535 : r, 0);
                    r = $urandom_range(0, 3);
                    gdy[i] = (r == 3) ? 65535 : r;
                end
                gmask[i] = ($urandom_range(0, 3) != 0);
            end
            rdy = 5'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
